// File: rtl/riscv_pkg.sv
// Shared fetch-side types: default queue depth and the fetch entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  // Default number of instruction entries buffered between fetch and decode.
  localparam int FQ_DEPTH_DEFAULT = 4;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetchq_fifo.sv
// Generic circular FIFO with synchronous clear; exposes the head entry and occupancy.
// Latency: a pushed entry is visible at head_dat the cycle after the push (no bypass).
// Backpressure: push is dropped only when full without a same-cycle pop; pop on empty is ignored.
//
// Ports:
//   i_riscv_pc_clk / i_riscv_pc_rst : clock, async active-high reset
//   clear                           : synchronous empty; push/pop that cycle are ignored
//   push_vld / push_dat             : write one entry at the tail
//   pop_vld                         : retire the head entry
//   head_dat                        : current head entry (undefined when count is zero)
//   count                           : number of valid entries, 0..DEPTH
module riscv_fetchq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   i_riscv_pc_clk,
  input  logic                   i_riscv_pc_rst,
  input  logic                   clear,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_vld,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign do_pop   = pop_vld && (count != '0);
  assign do_push  = push_vld && ((count != FULL_CNT) || do_pop);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge i_riscv_pc_clk or posedge i_riscv_pc_rst) begin
    if (i_riscv_pc_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge i_riscv_pc_clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/riscv_fetchq.sv
// Instruction fetch queue: credit-limited imem requests, PC tagging, in-order buffering to decode.
// Latency: response to instvalid is 1 cycle; request/grant and stallpc are combinational.
// Backpressure: requests stop once buffered + outstanding + to-be-dropped responses reach FQ_DEPTH.
//
// Ports:
//   i_riscv_pc_clk, i_riscv_pc_rst        : clock, async active-high reset
//   i_riscv_fetchq_pc, o_riscv_fetchq_stallpc : PC in; hold PC unless a request is granted
//   o_riscv_fetchq_imemreq/imemaddr, i_riscv_fetchq_imemgnt : imem request channel
//   i_riscv_fetchq_imemrvalid/imemrdata   : in-order imem read response
//   i_riscv_fetchq_flush                  : redirect, discard buffered and in-flight fetches
//   o_riscv_fetchq_instvalid/inst/instpc, i_riscv_fetchq_instready : decode handshake
module riscv_fetchq
  import riscv_pkg::*;
#(
  parameter int FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic        i_riscv_pc_clk,
  input  logic        i_riscv_pc_rst,
  input  logic [63:0] i_riscv_fetchq_pc,
  output logic        o_riscv_fetchq_stallpc,
  output logic        o_riscv_fetchq_imemreq,
  output logic [63:0] o_riscv_fetchq_imemaddr,
  input  logic        i_riscv_fetchq_imemgnt,
  input  logic        i_riscv_fetchq_imemrvalid,
  input  logic [31:0] i_riscv_fetchq_imemrdata,
  input  logic        i_riscv_fetchq_flush,
  output logic        o_riscv_fetchq_instvalid,
  output logic [31:0] o_riscv_fetchq_inst,
  output logic [63:0] o_riscv_fetchq_instpc,
  input  logic        i_riscv_fetchq_instready
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FQ_DEPTH);

  logic          grant;
  logic          resp_vld;
  logic          drop_vld;
  logic          pop_vld;
  logic [CW-1:0] occ_cnt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   inflight;
  logic [63:0]   tag_pc;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // Responses still owed by memory for fetches killed by a flush occupy credit
  // just like live ones, otherwise a fresh request could overrun the buffer.
  assign inflight = {1'b0, occ_cnt} + {1'b0, out_cnt} + {1'b0, drop_cnt};

  assign o_riscv_fetchq_imemreq  = !i_riscv_pc_rst && !i_riscv_fetchq_flush && (inflight < DEPTH_LIM);
  assign o_riscv_fetchq_imemaddr = i_riscv_fetchq_pc;
  assign grant                   = o_riscv_fetchq_imemreq && i_riscv_fetchq_imemgnt;
  assign o_riscv_fetchq_stallpc  = !grant;

  // While drop_cnt is nonzero the response belongs to a flushed fetch.
  assign drop_vld = i_riscv_fetchq_imemrvalid && (drop_cnt != '0);
  assign resp_vld = i_riscv_fetchq_imemrvalid && (drop_cnt == '0) && !i_riscv_fetchq_flush;

  assign push_entry = '{inst: i_riscv_fetchq_imemrdata, pc: tag_pc};

  assign o_riscv_fetchq_instvalid = (occ_cnt != '0);
  assign o_riscv_fetchq_inst      = o_riscv_fetchq_instvalid ? head_entry.inst : '0;
  assign o_riscv_fetchq_instpc    = o_riscv_fetchq_instvalid ? head_entry.pc   : '0;
  assign pop_vld                  = o_riscv_fetchq_instvalid && i_riscv_fetchq_instready;

  // On flush everything still owed by memory becomes droppable; a response
  // arriving in the flush cycle itself settles one of those debts.
  always_ff @(posedge i_riscv_pc_clk or posedge i_riscv_pc_rst) begin
    if (i_riscv_pc_rst) begin
      drop_cnt <= '0;
    end else if (i_riscv_fetchq_flush) begin
      drop_cnt <= drop_cnt + out_cnt - CW'(i_riscv_fetchq_imemrvalid);
    end else if (drop_vld) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Tag queue: one PC per granted request; its occupancy is the outstanding count.
  riscv_fetchq_fifo #(
    .WIDTH (64),
    .DEPTH (FQ_DEPTH)
  ) u_tag_q (
    .i_riscv_pc_clk (i_riscv_pc_clk),
    .i_riscv_pc_rst (i_riscv_pc_rst),
    .clear          (i_riscv_fetchq_flush),
    .push_vld       (grant),
    .push_dat       (i_riscv_fetchq_pc),
    .pop_vld        (resp_vld),
    .head_dat       (tag_pc),
    .count          (out_cnt)
  );

  // Instruction FIFO towards decode.
  riscv_fetchq_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_inst_q (
    .i_riscv_pc_clk (i_riscv_pc_clk),
    .i_riscv_pc_rst (i_riscv_pc_rst),
    .clear          (i_riscv_fetchq_flush),
    .push_vld       (resp_vld),
    .push_dat       (push_entry),
    .pop_vld        (pop_vld),
    .head_dat       (head_entry),
    .count          (occ_cnt)
  );

  // A response with nothing owed means the memory side has lost sync with us.
  a_no_stray_rsp : assert property (@(posedge i_riscv_pc_clk) disable iff (i_riscv_pc_rst)
    !(i_riscv_fetchq_imemrvalid && (out_cnt == '0) && (drop_cnt == '0)));

endmodule

// File: tb/tb_riscv_fetchq.sv
// Directed bench for riscv_fetchq: reset, single fetch, credit limit, flush drop, ordering, mid-run reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 1 unit later.
// Backpressure: decode ready and memory grant are driven per step.
module tb_riscv_fetchq;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        stallpc;
  logic        imemreq;
  logic [63:0] imemaddr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        flush;
  logic        instvalid;
  logic [31:0] inst;
  logic [63:0] instpc;
  logic        ready;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  riscv_fetchq dut (
    .i_riscv_pc_clk            (clk),
    .i_riscv_pc_rst            (rst),
    .i_riscv_fetchq_pc         (pc),
    .o_riscv_fetchq_stallpc    (stallpc),
    .o_riscv_fetchq_imemreq    (imemreq),
    .o_riscv_fetchq_imemaddr   (imemaddr),
    .i_riscv_fetchq_imemgnt    (gnt),
    .i_riscv_fetchq_imemrvalid (rvalid),
    .i_riscv_fetchq_imemrdata  (rdata),
    .i_riscv_fetchq_flush      (flush),
    .o_riscv_fetchq_instvalid  (instvalid),
    .o_riscv_fetchq_inst       (inst),
    .o_riscv_fetchq_instpc     (instpc),
    .i_riscv_fetchq_instready  (ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] drain_inst [3];
  logic [63:0] drain_pc   [3];

  initial begin
    rst = 1'b1; pc = 64'h8000_0062; gnt = 1'b1; rvalid = 1'b0; rdata = '0;
    flush = 1'b0; ready = 1'b1;
    drain_inst[0] = 32'hD000_0003; drain_pc[0] = 64'h100C;
    drain_inst[1] = 32'hD000_0004; drain_pc[1] = 64'h1010;
    drain_inst[2] = 32'hD000_0005; drain_pc[2] = 64'h1014;

    // Reset state
    #2;
    check("rst_imemreq", imemreq, 1'b0);
    check("rst_stallpc", stallpc, 1'b1);
    check("rst_instvalid", instvalid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_instpc", instpc, 64'h0);

    // Single fetch end to end
    cyc(); rst = 1'b0; #1;
    check("f1_imemreq", imemreq, 1'b1);
    check("f1_stallpc", stallpc, 1'b0);
    check("f1_imemaddr", imemaddr, 64'h8000_0062);
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013; #1;
    check("f1_not_yet", instvalid, 1'b0);
    cyc(); rvalid = 1'b0; #1;
    check("f1_instvalid", instvalid, 1'b1);
    check("f1_inst", inst, 32'h0000_0013);
    check("f1_instpc", instpc, 64'h8000_0062);
    cyc(); #1;
    check("f1_popped", instvalid, 1'b0);

    // Credit limit with decode stalled: four grants then stall
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pc = 64'h1000 + 64'(4 * k); gnt = 1'b1;
      rvalid = (k != 0); rdata = 32'hD000_0000 + 32'(k - 1);
      #1;
      check($sformatf("cred_req%0d", k), imemreq, (k < 4));
      check($sformatf("cred_stall%0d", k), stallpc, (k >= 4));
      cyc();
    end
    rvalid = 1'b0; ready = 1'b1; #1;
    check("cred_full_req", imemreq, 1'b0);
    check("cred_full_stall", stallpc, 1'b1);
    check("cred_head_inst", inst, 32'hD000_0000);
    check("cred_head_pc", instpc, 64'h1000);
    cyc(); ready = 1'b0; #1;
    check("cred_regrant", stallpc, 1'b0);
    check("cred_regrant_addr", imemaddr, 64'h1010);
    check("cred_head1", inst, 32'hD000_0001);
    cyc(); pc = 64'h1014; #1;
    check("cred_stall_again", imemreq, 1'b0);

    // Push and pop in one cycle with credit exhausted; order and tags preserved
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'hD000_0004; ready = 1'b1; #1;
    check("pp1_head_inst", inst, 32'hD000_0001);
    check("pp1_head_pc", instpc, 64'h1004);
    cyc(); rvalid = 1'b0; ready = 1'b0; gnt = 1'b1; #1;
    check("pp2_head_inst", inst, 32'hD000_0002);
    check("pp2_head_pc", instpc, 64'h1008);
    check("pp2_req", imemreq, 1'b1);
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'hD000_0005; ready = 1'b1; #1;
    check("pp3_req", imemreq, 1'b0);
    check("pp3_head_inst", inst, 32'hD000_0002);
    cyc(); rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("drain_inst%0d", k), inst, drain_inst[k]);
      check($sformatf("drain_pc%0d", k), instpc, drain_pc[k]);
      cyc();
    end
    #1;
    check("drain_empty", instvalid, 1'b0);

    // Flush with three fetches outstanding; their responses are dropped
    for (int k = 0; k < 3; k++) begin
      pc = 64'h2000 + 64'(4 * k); gnt = 1'b1; #1;
      check($sformatf("fl_issue%0d", k), stallpc, 1'b0);
      cyc();
    end
    flush = 1'b1; pc = 64'h3000; #1;
    check("fl_req_off", imemreq, 1'b0);
    check("fl_stall", stallpc, 1'b1);
    cyc(); flush = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_0000; #1;
    check("fl_new_req", imemreq, 1'b1);
    check("fl_new_addr", imemaddr, 64'h3000);
    check("fl_new_grant", stallpc, 1'b0);
    cyc(); gnt = 1'b0; rdata = 32'hBAD0_0001; #1;
    check("fl_drop1", instvalid, 1'b0);
    cyc(); rdata = 32'hBAD0_0002; #1;
    check("fl_drop2", instvalid, 1'b0);
    cyc(); rdata = 32'hAAAA_0001; #1;
    check("fl_drop3", instvalid, 1'b0);
    cyc(); rvalid = 1'b0; #1;
    check("fl_live_vld", instvalid, 1'b1);
    check("fl_live_inst", inst, 32'hAAAA_0001);
    check("fl_live_pc", instpc, 64'h3000);
    cyc(); #1;
    check("fl_live_popped", instvalid, 1'b0);

    // Reset with two outstanding and two buffered
    ready = 1'b0; gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc = 64'h4000 + 64'(4 * k);
      rvalid = (k == 1) || (k == 2); rdata = 32'hC000_0000 + 32'(k);
      #1;
      check($sformatf("mr_issue%0d", k), imemreq, 1'b1);
      cyc();
    end
    rvalid = 1'b0; #1;
    check("mr_buffered", instvalid, 1'b1);
    rst = 1'b1; #1;
    check("mr_rst_req", imemreq, 1'b0);
    check("mr_rst_stall", stallpc, 1'b1);
    check("mr_rst_vld", instvalid, 1'b0);
    check("mr_rst_inst", inst, 32'h0);
    check("mr_rst_pc", instpc, 64'h0);
    cyc(); rst = 1'b0; pc = 64'h5000; #1;
    check("mr_after_req", imemreq, 1'b1);
    check("mr_after_grant", stallpc, 1'b0);
    check("mr_after_empty", instvalid, 1'b0);
    cyc(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0055; #1;
    cyc(); rvalid = 1'b0; #1;
    check("mr_resp_vld", instvalid, 1'b1);
    check("mr_resp_inst", inst, 32'h0000_0055);
    check("mr_resp_pc", instpc, 64'h5000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/riscv_fetchq.md
RISCV_FETCHQ -- requirements
Module: riscv_fetchq

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, number of instruction entries buffered (power of two, >=2).
REQ-002 SHALL have port i_riscv_pc_clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port i_riscv_pc_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_riscv_fetchq_pc  input  64  current PC from PC register.
REQ-005 SHALL have port o_riscv_fetchq_stallpc  output  1  hold PC register, high unless a request is granted this cycle.
REQ-006 SHALL have port o_riscv_fetchq_imemreq  output  1  instruction memory read request.
REQ-007 SHALL have port o_riscv_fetchq_imemaddr  output  64  request address, equal to i_riscv_fetchq_pc.
REQ-008 SHALL have port i_riscv_fetchq_imemgnt  input  1  memory accepts request this cycle.
REQ-009 SHALL have ports i_riscv_fetchq_imemrvalid  input  1, and i_riscv_fetchq_imemrdata  input  32, in-order read response, arriving >=1 cycle after grant.
REQ-010 SHALL have port i_riscv_fetchq_flush  input  1  redirect, discard all buffered and in-flight fetches.
REQ-011 SHALL have ports o_riscv_fetchq_instvalid  output  1, o_riscv_fetchq_inst  output  32, o_riscv_fetchq_instpc  output  64, to decode.
REQ-012 SHALL have port i_riscv_fetchq_instready  input  1  decode accepts head entry.

Function
REQ-013 Credit: SHALL assert imemreq only when !flush and (occupancy + outstanding) < FQ_DEPTH.
REQ-014 Grant (imemreq && imemgnt) SHALL push imemaddr into a PC-tag queue, increment outstanding, drive stallpc low that same cycle.
REQ-015 stallpc SHALL equal !(imemreq && imemgnt), combinational.
REQ-016 Response (rvalid, drop counter zero) SHALL write {rdata, popped tag PC} to instruction FIFO and decrement outstanding; entry visible at outputs the next cycle (latency 1, no bypass).
REQ-017 instvalid SHALL equal FIFO non-empty; inst/instpc SHALL show head entry; pop on instvalid && instready.
REQ-018 Push and pop in the same cycle SHALL both occur, occupancy unchanged, including when FIFO is full.
REQ-019 Credit rule guarantees no overflow; rvalid with zero outstanding and zero drop count is illegal (assertion).
REQ-020 Flush SHALL, next edge: empty FIFO and tag queue, load drop counter with outstanding minus (1 if rvalid this cycle), zero outstanding; pop/push that cycle ignored.
REQ-021 Each rvalid while drop counter nonzero SHALL be discarded and decrement drop counter; credit counts drop counter as outstanding.
REQ-022 Flush while drop counter nonzero SHALL add new in-flight count to drop counter.
REQ-023 Pointers SHALL wrap modulo FQ_DEPTH; occupancy counter width clog2(FQ_DEPTH)+1.

Reset
REQ-024 Reset SHALL clear pointers, occupancy, outstanding, drop counter; instvalid=0, imemreq=0, stallpc=1, inst=0, instpc=0.
REQ-025 Reset asserted mid-transaction SHALL abandon in-flight responses; first cycle after release behaves as empty with full credit.

Structure
REQ-026 FQ_DEPTH default and the fetch entry struct {inst[31:0], pc[63:0]} SHALL live in shared package riscv_pkg.
REQ-027 SHALL instantiate one generic sub-module riscv_fetchq_fifo (parameter width/depth), used for both tag queue and instruction FIFO.

Verification
REQ-028 After reset, pc=0x80000062, gnt=1, rvalid 1 cycle later with rdata=0x00000013, ready=1 -> instvalid next cycle, inst=0x00000013, instpc=0x80000062.
REQ-029 ready=0, gnt=1, rvalid every cycle -> exactly 4 grants, then imemreq=0, stallpc=1; ready=1 for one cycle -> one new grant.
REQ-030 3 outstanding, flush, then 3 rvalids -> all dropped, instvalid stays 0, new request to new PC on cycle after flush, its response delivered.
REQ-031 Full FIFO, ready=1 and rvalid same cycle -> occupancy stays 4, order preserved, pc tags match issue order.
REQ-032 Reset asserted with 2 outstanding and FIFO holding 2 -> all outputs at reset values; stray rvalid after release flagged by assertion only when none outstanding.
